// File: rtl/cosx_sched_pkg.sv
// Shared types and helpers for the cosx accelerator scheduler.
package cosx_sched_pkg;

  localparam int DEF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cosx_scheduler_rr_pick.sv
// Combinational round-robin picker: first active request after the pointer, wrapping.
module rr_pick
  import cosx_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_index,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  // Scan ptr+1, ptr+2, ... modulo NREQ and keep the first hit.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_index         = w_cand;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/cosx_scheduler.sv
// Round-robin scheduler sharing one cosx accelerator among NREQ requesters,
// with ready-edge completion detection and a watchdog abort.
module cosx_scheduler
  import cosx_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ*W-1:0] i_req_x,
  input  logic [NREQ*W-1:0] i_req_y,
  output logic [NREQ-1:0] o_ack,
  output logic [NREQ-1:0] o_done,
  output logic [W-1:0]    o_result,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_acc_start,
  output logic [W-1:0]    o_acc_x,
  output logic [W-1:0]    o_acc_y,
  input  logic            i_acc_ready,
  input  logic [W-1:0]    i_acc_cosx
);

  localparam int IW = clog2(NREQ);
  localparam int TW = clog2(TIMEOUT + 1);

  state_e          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_owner;
  logic [TW-1:0]   r_timer;
  logic            r_ready_q;
  logic [NREQ-1:0] r_ack, r_done;
  logic [W-1:0]    r_result, r_acc_x, r_acc_y;
  logic            r_err, r_busy, r_acc_start;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any, w_edge, w_expired;
  logic [W-1:0]    w_pick_x, w_pick_y;
  logic [NREQ-1:0] w_owner_oh;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_index (w_idx),
    .o_any   (w_any)
  );

  assign w_edge     = ~r_ready_q & i_acc_ready;
  assign w_expired  = (r_timer == TW'(TIMEOUT));
  assign w_pick_x   = i_req_x[w_idx*W +: W];
  assign w_pick_y   = i_req_y[w_idx*W +: W];
  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  // Next-state logic; the ready edge takes priority over the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = (|i_req) ? ST_GRANT : ST_IDLE;
      ST_GRANT:  w_next = w_any ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT:   w_next = (w_edge || w_expired) ? ST_DONE : ST_WAIT;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_owner     <= '0;
      r_timer     <= '0;
      r_ready_q   <= 1'b0;
      r_ack       <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_acc_start <= 1'b0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
    end else begin
      r_state     <= w_next;
      r_ready_q   <= i_acc_ready;
      r_busy      <= (w_next != ST_IDLE);
      r_ack       <= '0;
      r_done      <= '0;
      r_acc_start <= 1'b0;
      case (r_state)
        ST_GRANT: begin
          if (w_any) begin
            r_ack       <= w_grant;
            r_owner     <= w_idx;
            r_acc_x     <= w_pick_x;
            r_acc_y     <= w_pick_y;
            r_acc_start <= 1'b1;
          end
        end
        ST_LAUNCH: r_timer <= '0;
        ST_WAIT: begin
          r_timer <= w_expired ? r_timer : r_timer + TW'(1);
          if (w_edge) begin
            r_result <= i_acc_cosx;
            r_err    <= 1'b0;
            r_done   <= w_owner_oh;
          end else if (w_expired) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= w_owner_oh;
          end
        end
        ST_DONE: r_ptr <= r_owner;
        default: r_timer <= r_timer;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_acc_start = r_acc_start;
  assign o_acc_x     = r_acc_x;
  assign o_acc_y     = r_acc_y;

endmodule

// File: tb/tb_cosx_scheduler.sv
// Scoreboard bench for cosx_scheduler with a behavioural accelerator stand-in.
module tb_cosx_scheduler;

  typedef struct {
    int          owner;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] bx [4];
  logic [15:0] by [4];
  logic [63:0] req_x, req_y;
  logic [3:0]  ack, done;
  logic [15:0] result, acc_x, acc_y, acc_cosx;
  logic        err, busy, acc_start, acc_ready;
  logic        hang = 1'b0;

  logic        m_active = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] m_cosx = 16'h0000;
  logic [15:0] m_x = 16'h0000, m_y = 16'h0000;
  int          m_cnt = 0;

  int   cyc = 0, launch_cyc = 0, start_cnt = 0, ack_cnt = 0;
  int   n_checks = 0, n_pass = 0;
  exp_t exp_q [$];
  int   grant_q [$];

  always #100 clk = ~clk;

  assign req_x     = {bx[3], bx[2], bx[1], bx[0]};
  assign req_y     = {by[3], by[2], by[1], by[0]};
  assign acc_ready = m_ready;
  assign acc_cosx  = m_cosx;

  cosx_scheduler #(.NREQ(4), .W(16), .TIMEOUT(15)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_ack(ack), .o_done(done), .o_result(result), .o_err(err), .o_busy(busy),
    .o_acc_start(acc_start), .o_acc_x(acc_x), .o_acc_y(acc_y),
    .i_acc_ready(acc_ready), .i_acc_cosx(acc_cosx)
  );

  function automatic logic [15:0] cos_model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] t;
    t = x * 16'd3;
    return t ^ {y[7:0], y[7:0]} ^ 16'h1357;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Accelerator stand-in: latency 2 + x[1:0] cycles, one-cycle ready pulse; never told about resets.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    m_ready <= 1'b0;
    if (acc_start && !hang) begin
      m_active <= 1'b1;
      m_cnt    <= 2 + int'(acc_x[1:0]);
      m_x      <= acc_x;
      m_y      <= acc_y;
    end else if (m_active) begin
      if (m_cnt == 0) begin
        m_active <= 1'b0;
        m_ready  <= 1'b1;
        m_cosx   <= cos_model(m_x, m_y);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Scoreboard push on every ack; launch bookkeeping.
  always @(negedge clk) begin
    exp_t e;
    if (acc_start) begin
      start_cnt  <= start_cnt + 1;
      launch_cyc <= cyc;
    end
    if (ack != 4'b0000) begin
      ack_cnt <= ack_cnt + 1;
      e.owner = oh_idx(ack);
      e.err   = hang;
      e.res   = hang ? 16'h0000 : cos_model(bx[e.owner], by[e.owner]);
      exp_q.push_back(e);
      grant_q.push_back(e.owner);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    hang  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    grant_q.delete();
  endtask

  task automatic wait_done(output logic [3:0] d, output logic [15:0] r, output logic e, output bit ok);
    ok = 1'b0; d = 4'b0000; r = 16'h0000; e = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done != 4'b0000) begin
        d = done; r = result; e = err; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (acc_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pops one scoreboard entry and one grant; compares against the observed completion.
  task automatic check_job(input string name, input int exp_grant, input logic [3:0] d,
                           input logic [15:0] r, input logic e, input bit ok);
    exp_t ex;
    int   g;
    logic [3:0] exp_done;
    n_checks++;
    if (!ok || exp_q.size() == 0 || grant_q.size() == 0) begin
      $display("FAIL %s: completion seen=%0b pending=%0d, required one done", name, ok, exp_q.size());
    end else begin
      ex = exp_q.pop_front();
      g  = grant_q.pop_front();
      exp_done = 4'b0001 << ex.owner;
      if (g !== exp_grant || {d, r, e} !== {exp_done, ex.res, ex.err})
        $display("FAIL %s: grant=%0d done=%b result=%h err=%b, required grant=%0d done=%b result=%h err=%b",
                 name, g, d, r, e, exp_grant, exp_done, ex.res, ex.err);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ack, done, err, busy, acc_start} !== 11'd0)
      $display("FAIL reset_ctrl: got %b, required 0", {ack, done, err, busy, acc_start});
    else n_pass++;
    n_checks++;
    if ({result, acc_x, acc_y} !== 48'd0)
      $display("FAIL reset_data: got %h, required 0", {result, acc_x, acc_y});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] d; logic [15:0] r; logic e; bit ok; int s0, a0;
    do_reset();
    bx[0] = 16'h0200; by[0] = 16'd6;
    s0 = start_cnt; a0 = ack_cnt;
    req = 4'b0001;
    wait_done(d, r, e, ok);
    req = 4'b0000;
    check_job("single", 0, d, r, e, ok);
    n_checks++;
    if (start_cnt - s0 !== 1 || ack_cnt - a0 !== 1)
      $display("FAIL single_pulses: start=%0d ack=%0d, required 1 and 1", start_cnt - s0, ack_cnt - a0);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 5'd0 || result !== cos_model(16'h0200, 16'd6))
      $display("FAIL single_hold: busy=%b done=%b result=%h, required 0 0 %h",
               busy, done, result, cos_model(16'h0200, 16'd6));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] d; logic [15:0] r; logic e; bit ok;
    do_reset();
    bx[0] = 16'h0311; by[0] = 16'd4;
    req = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      wait_done(d, r, e, ok);
      if (j == 2) req = 4'b0000;
      check_job("back_to_back", 0, d, r, e, ok);
    end
  endtask

  task automatic test_contention();
    logic [3:0] d; logic [15:0] r; logic e; bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bx[i] = 16'h0100 * 16'(i + 1) + 16'(i);
      by[i] = 16'(i + 3);
    end
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_done(d, r, e, ok);
      if (j == 7) req = 4'b0000;
      check_job("contention", j % 4, d, r, e, ok);
    end
  endtask

  task automatic test_rr_resume();
    logic [3:0] d; logic [15:0] r; logic e; bit ok;
    do_reset();
    req = 4'b0100;
    wait_done(d, r, e, ok);
    req = 4'b0000;
    check_job("rr_serve2", 2, d, r, e, ok);
    repeat (2) @(negedge clk);
    req = 4'b0011;
    wait_done(d, r, e, ok);
    req = 4'b0010;
    check_job("rr_resume0", 0, d, r, e, ok);
    wait_done(d, r, e, ok);
    req = 4'b0000;
    check_job("rr_resume1", 1, d, r, e, ok);
  endtask

  task automatic test_timeout();
    logic [3:0] d; logic [15:0] r; logic e; bit ok;
    do_reset();
    hang = 1'b1;
    req  = 4'b1000;
    wait_done(d, r, e, ok);
    req = 4'b0000;
    n_checks++;
    if (cyc - launch_cyc !== 17)
      $display("FAIL timeout_latency: got %0d cycles after launch, required 17", cyc - launch_cyc);
    else n_pass++;
    check_job("timeout", 3, d, r, e, ok);
    hang = 1'b0;
    @(negedge clk);
    req = 4'b0100;
    wait_done(d, r, e, ok);
    req = 4'b0000;
    check_job("after_timeout", 2, d, r, e, ok);
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] d; logic [15:0] r; logic e; bit ok; int dc, bc;
    do_reset();
    bx[0] = 16'h0303; by[0] = 16'd5;
    req = 4'b0001;
    wait_start(ok);
    n_checks++;
    if (!ok) $display("FAIL midwait_launch: no acc_start, required one");
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({ack, done, err, busy, acc_start, result, acc_x, acc_y} !== 59'd0)
      $display("FAIL midwait_reset: got %h, required 0", {ack, done, err, busy, acc_start, result, acc_x, acc_y});
    else n_pass++;
    rst_n = 1'b1;
    exp_q.delete();
    grant_q.delete();
    dc = 0; bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done != 4'b0000) dc++;
      if (busy) bc++;
    end
    n_checks++;
    if (dc !== 0 || bc !== 0)
      $display("FAIL midwait_silent: done cycles=%0d busy cycles=%0d, required 0 0", dc, bc);
    else n_pass++;
    req = 4'b0010;
    wait_done(d, r, e, ok);
    req = 4'b0000;
    check_job("after_midwait", 1, d, r, e, ok);
  endtask

  task automatic test_drop_req();
    logic [3:0] d; logic [15:0] r; logic e; bit ok;
    do_reset();
    bx[1] = 16'h0a52; by[1] = 16'd9;
    req = 4'b0010;
    wait_start(ok);
    req = 4'b0000;
    wait_done(d, r, e, ok);
    check_job("drop_req", 1, d, r, e, ok);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bx[i] = 16'h0000;
      by[i] = 16'h0000;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_rr_resume();
    test_timeout();
    test_reset_mid_wait();
    test_drop_req();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
